// File: rtl/id_operand_fwd.sv
// Decode-stage operand unit: register file, EXE/MEM/WB operand forwarding,
// load-use stall detection, branch equality compare and the ID/EX register.
module id_operand_fwd #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REG_AW    = 5,
  parameter bit          BYPASS_WB = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic [REG_AW-1:0] in_raddr_a,
  input  logic [REG_AW-1:0] in_raddr_b,
  input  logic              in_use_a,
  input  logic              in_use_b,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [REG_AW-1:0] in_waddr,
  input  logic              in_wen,
  input  logic              in_is_load,
  input  logic              exe_wen,
  input  logic              exe_is_load,
  input  logic [REG_AW-1:0] exe_waddr,
  input  logic [DATA_W-1:0] exe_wdata,
  input  logic              mem_wen,
  input  logic [REG_AW-1:0] mem_waddr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              wb_wen,
  input  logic [REG_AW-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              flush,
  output logic              rs_eq_rt,
  output logic              stall,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [DATA_W-1:0] out_da,
  output logic [DATA_W-1:0] out_db,
  output logic [DATA_W-1:0] out_imm,
  output logic [REG_AW-1:0] out_waddr,
  output logic              out_wen,
  output logic              out_is_load
);

  localparam int unsigned PC_W   = 32;
  localparam int unsigned N_REGS = 1 << REG_AW;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] da;
    logic [DATA_W-1:0] db;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] waddr;
    logic              wen;
    logic              is_load;
  } idex_t;

  logic [DATA_W-1:0] regs [N_REGS];
  logic [DATA_W-1:0] rf_a, rf_b;
  logic [DATA_W-1:0] opnd_a, opnd_b;
  logic              dep_a, dep_b;
  logic              fire;
  logic              valid_q;
  idex_t             idex_q, idex_d;

  // Register file; entry 0 is never written so it always reads zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_REGS; i++) begin
        regs[REG_AW'(i)] <= '0;
      end
    end else if (wb_wen && (wb_waddr != '0)) begin
      regs[wb_waddr] <= wb_wdata;
    end
  end

  assign rf_a = regs[in_raddr_a];
  assign rf_b = regs[in_raddr_b];

  // Operand A: youngest producer wins; an EXE load cannot forward yet.
  always_comb begin
    opnd_a = rf_a;
    if (in_raddr_a == '0) begin
      opnd_a = '0;
    end else if (exe_wen && (exe_waddr == in_raddr_a) && !exe_is_load) begin
      opnd_a = exe_wdata;
    end else if (mem_wen && (mem_waddr == in_raddr_a)) begin
      opnd_a = mem_wdata;
    end else if (BYPASS_WB && wb_wen && (wb_waddr == in_raddr_a)) begin
      opnd_a = wb_wdata;
    end
  end

  // Operand B: same selection as A.
  always_comb begin
    opnd_b = rf_b;
    if (in_raddr_b == '0) begin
      opnd_b = '0;
    end else if (exe_wen && (exe_waddr == in_raddr_b) && !exe_is_load) begin
      opnd_b = exe_wdata;
    end else if (mem_wen && (mem_waddr == in_raddr_b)) begin
      opnd_b = mem_wdata;
    end else if (BYPASS_WB && wb_wen && (wb_waddr == in_raddr_b)) begin
      opnd_b = wb_wdata;
    end
  end

  assign rs_eq_rt = (opnd_a == opnd_b);

  // Load-use hazard: only operands actually read can depend on the load.
  assign dep_a = in_use_a && (exe_waddr == in_raddr_a);
  assign dep_b = in_use_b && (exe_waddr == in_raddr_b);
  assign stall = in_valid && exe_wen && exe_is_load && (exe_waddr != '0) && (dep_a || dep_b);

  assign in_ready = !reset && !stall && !flush && (!valid_q || out_ready);
  assign fire     = in_valid && in_ready;

  always_comb begin
    idex_d         = idex_q;
    idex_d.pc      = in_pc;
    idex_d.da      = opnd_a;
    idex_d.db      = opnd_b;
    idex_d.imm     = in_imm;
    idex_d.waddr   = in_waddr;
    idex_d.wen     = in_wen;
    idex_d.is_load = in_is_load;
  end

  // ID/EX register; a flush only drops valid, data fields keep their value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      idex_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (fire) begin
      valid_q <= 1'b1;
      idex_q  <= idex_d;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid   = valid_q;
  assign out_pc      = idex_q.pc;
  assign out_da      = idex_q.da;
  assign out_db      = idex_q.db;
  assign out_imm     = idex_q.imm;
  assign out_waddr   = idex_q.waddr;
  assign out_wen     = idex_q.wen;
  assign out_is_load = idex_q.is_load;

endmodule

// File: tb/tb_id_operand_fwd.sv
// Randomised and directed bench for id_operand_fwd, run with and without
// WB bypass side by side against a producer-list reference model.
module tb_id_operand_fwd;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          in_valid, in_use_a, in_use_b, in_wen, in_is_load;
  logic [31:0]   in_pc;
  logic [AW-1:0] in_raddr_a, in_raddr_b, in_waddr;
  logic [DW-1:0] in_imm;
  logic          exe_wen, exe_is_load;
  logic [AW-1:0] exe_waddr;
  logic [DW-1:0] exe_wdata;
  logic          mem_wen;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          wb_wen;
  logic [AW-1:0] wb_waddr;
  logic [DW-1:0] wb_wdata;
  logic          flush, out_ready;

  // index 1: BYPASS_WB=1, index 0: BYPASS_WB=0
  logic [1:0]    rdy, stl, eq, ov, owen, oisl;
  logic [31:0]   opc   [2];
  logic [DW-1:0] oda   [2];
  logic [DW-1:0] odb   [2];
  logic [DW-1:0] oimm  [2];
  logic [AW-1:0] owa   [2];

  id_operand_fwd #(.DATA_W(DW), .REG_AW(AW), .BYPASS_WB(1'b1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_pc(in_pc), .in_raddr_a(in_raddr_a), .in_raddr_b(in_raddr_b),
    .in_use_a(in_use_a), .in_use_b(in_use_b), .in_imm(in_imm),
    .in_waddr(in_waddr), .in_wen(in_wen), .in_is_load(in_is_load),
    .exe_wen(exe_wen), .exe_is_load(exe_is_load), .exe_waddr(exe_waddr),
    .exe_wdata(exe_wdata), .mem_wen(mem_wen), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .wb_wen(wb_wen), .wb_waddr(wb_waddr),
    .wb_wdata(wb_wdata), .flush(flush), .rs_eq_rt(eq[1]), .stall(stl[1]),
    .out_valid(ov[1]), .out_ready(out_ready), .out_pc(opc[1]),
    .out_da(oda[1]), .out_db(odb[1]), .out_imm(oimm[1]),
    .out_waddr(owa[1]), .out_wen(owen[1]), .out_is_load(oisl[1])
  );

  id_operand_fwd #(.DATA_W(DW), .REG_AW(AW), .BYPASS_WB(1'b0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_pc(in_pc), .in_raddr_a(in_raddr_a), .in_raddr_b(in_raddr_b),
    .in_use_a(in_use_a), .in_use_b(in_use_b), .in_imm(in_imm),
    .in_waddr(in_waddr), .in_wen(in_wen), .in_is_load(in_is_load),
    .exe_wen(exe_wen), .exe_is_load(exe_is_load), .exe_waddr(exe_waddr),
    .exe_wdata(exe_wdata), .mem_wen(mem_wen), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .wb_wen(wb_wen), .wb_waddr(wb_waddr),
    .wb_wdata(wb_wdata), .flush(flush), .rs_eq_rt(eq[0]), .stall(stl[0]),
    .out_valid(ov[0]), .out_ready(out_ready), .out_pc(opc[0]),
    .out_da(oda[0]), .out_db(odb[0]), .out_imm(oimm[0]),
    .out_waddr(owa[0]), .out_wen(owen[0]), .out_is_load(oisl[0])
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [DW-1:0] m_rf [32];
  logic          m_valid, m_wen, m_is_load;
  logic [31:0]   m_pc;
  logic [DW-1:0] m_imm;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_da [2];
  logic [DW-1:0] m_db [2];

  // Value of r as seen by ID: search in-flight results youngest first.
  function automatic logic [DW-1:0] m_operand(input logic [AW-1:0] r, input int bp);
    logic [AW-1:0] qa [$];
    logic [DW-1:0] qd [$];
    if (r == 0) return '0;
    if (exe_wen && !exe_is_load) begin qa.push_back(exe_waddr); qd.push_back(exe_wdata); end
    if (mem_wen) begin qa.push_back(mem_waddr); qd.push_back(mem_wdata); end
    if (bp != 0 && wb_wen) begin qa.push_back(wb_waddr); qd.push_back(wb_wdata); end
    foreach (qa[i]) if (qa[i] == r) return qd[i];
    return m_rf[r];
  endfunction

  function automatic bit m_stall();
    bit dep_a = in_use_a && (in_raddr_a == exe_waddr);
    bit dep_b = in_use_b && (in_raddr_b == exe_waddr);
    return in_valid && exe_wen && exe_is_load && (exe_waddr != 0) && (dep_a || dep_b);
  endfunction

  function automatic bit m_ready();
    return !reset && !m_stall() && !flush && (!m_valid || out_ready);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_valid = 0; m_wen = 0; m_is_load = 0; m_pc = '0; m_imm = '0; m_waddr = '0;
    for (int k = 0; k < 2; k++) begin m_da[k] = '0; m_db[k] = '0; end
  endtask

  task automatic model_edge();
    bit f = in_valid && m_ready();
    logic [DW-1:0] na [2];
    logic [DW-1:0] nb [2];
    for (int k = 0; k < 2; k++) begin
      na[k] = m_operand(in_raddr_a, k);
      nb[k] = m_operand(in_raddr_b, k);
    end
    if (flush) m_valid = 0;
    else if (f) begin
      m_valid = 1; m_pc = in_pc; m_imm = in_imm; m_waddr = in_waddr;
      m_wen = in_wen; m_is_load = in_is_load;
      for (int k = 0; k < 2; k++) begin m_da[k] = na[k]; m_db[k] = nb[k]; end
    end else if (out_ready) m_valid = 0;
    if (wb_wen && wb_waddr != 0) m_rf[wb_waddr] = wb_wdata;
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("stall%0d", k), 32'(stl[k]), 32'(m_stall()));
      check($sformatf("in_ready%0d", k), 32'(rdy[k]), 32'(m_ready()));
      check($sformatf("rs_eq_rt%0d", k), 32'(eq[k]),
            32'(m_operand(in_raddr_a, k) == m_operand(in_raddr_b, k)));
      check($sformatf("out_valid%0d", k), 32'(ov[k]), 32'(m_valid));
      check($sformatf("out_pc%0d", k), opc[k], m_pc);
      check($sformatf("out_da%0d", k), oda[k], m_da[k]);
      check($sformatf("out_db%0d", k), odb[k], m_db[k]);
      check($sformatf("out_imm%0d", k), oimm[k], m_imm);
      check($sformatf("out_waddr%0d", k), 32'(owa[k]), 32'(m_waddr));
      check($sformatf("out_wen%0d", k), 32'(owen[k]), 32'(m_wen));
      check($sformatf("out_is_load%0d", k), 32'(oisl[k]), 32'(m_is_load));
    end
  endtask

  // Called with inputs driven just after a falling edge; returns at the next one.
  task automatic step();
    #1 check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 0; in_use_a = 0; in_use_b = 0; in_wen = 0; in_is_load = 0;
    in_pc = '0; in_raddr_a = '0; in_raddr_b = '0; in_waddr = '0; in_imm = '0;
    exe_wen = 0; exe_is_load = 0; exe_waddr = '0; exe_wdata = '0;
    mem_wen = 0; mem_waddr = '0; mem_wdata = '0;
    wb_wen = 0; wb_waddr = '0; wb_wdata = '0;
    flush = 0; out_ready = 1;
  endtask

  task automatic issue(input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                       input logic ua, input logic ub);
    in_valid = 1; in_raddr_a = ra; in_raddr_b = rb; in_use_a = ua; in_use_b = ub;
    in_pc = $urandom; in_imm = $urandom; in_waddr = AW'($urandom_range(0, 31));
    in_wen = 1'($urandom); in_is_load = 1'($urandom);
  endtask

  // Asserts reset mid-cycle with a WB write pending that must not land.
  task automatic apply_reset();
    #2 reset = 1;
    wb_wen = 1; wb_waddr = 5'd9; wb_wdata = 32'hDEAD_BEEF;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_valid%0d", k), 32'(ov[k]), 32'd0);
      check($sformatf("rst_ready%0d", k), 32'(rdy[k]), 32'd0);
      check($sformatf("rst_pc%0d", k), opc[k], 32'd0);
      check($sformatf("rst_da%0d", k), oda[k], 32'd0);
      check($sformatf("rst_db%0d", k), odb[k], 32'd0);
      check($sformatf("rst_imm%0d", k), oimm[k], 32'd0);
      check($sformatf("rst_flags%0d", k), {27'd0, owa[k]} | 32'(owen[k]) | 32'(oisl[k]), 32'd0);
    end
    model_clear();
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    idle();
  endtask

  initial begin
    reset = 1;
    idle();
    model_clear();
    @(negedge clk);
    apply_reset();

    // reset state: r5/r6 and r9 (written only during reset) all read 0
    issue(5'd5, 5'd6, 1, 1);
    step();
    check("r5r6_da", oda[1], 32'd0);
    check("r5r6_db", odb[1], 32'd0);
    issue(5'd9, 5'd9, 1, 1);
    step();
    check("r9_after_reset", oda[1], 32'd0);

    // same-cycle WB bypass versus regfile-only read
    idle(); issue(5'd3, 5'd0, 1, 0);
    wb_wen = 1; wb_waddr = 5'd3; wb_wdata = 32'h1234;
    step();
    check("wb_bypass1", oda[1], 32'h1234);
    check("wb_bypass0", oda[0], 32'd0);
    idle(); issue(5'd3, 5'd0, 1, 0);
    step();
    check("wb_later0", oda[0], 32'h1234);

    // EXE shadows MEM shadows WB
    idle(); issue(5'd4, 5'd4, 1, 1);
    exe_wen = 1; exe_waddr = 5'd4; exe_wdata = 32'hA;
    mem_wen = 1; mem_waddr = 5'd4; mem_wdata = 32'hB;
    wb_wen = 1;  wb_waddr = 5'd4;  wb_wdata = 32'hC;
    step();
    check("exe_prio1", oda[1], 32'hA);
    check("exe_prio0", odb[0], 32'hA);
    exe_wen = 0; in_valid = 1;
    step();
    check("mem_prio", oda[1], 32'hB);

    // load-use stall then forward from MEM
    idle(); issue(5'd7, 5'd1, 1, 1);
    exe_wen = 1; exe_is_load = 1; exe_waddr = 5'd7; exe_wdata = 32'h99;
    step();
    check("bubble", 32'(ov[1]), 32'd0);
    exe_wen = 0; exe_is_load = 0;
    mem_wen = 1; mem_waddr = 5'd7; mem_wdata = 32'h55;
    step();
    check("load_fwd_valid", 32'(ov[1]), 32'd1);
    check("load_fwd_da", oda[1], 32'h55);

    // unused operand does not stall; r0 ignores writes
    idle(); issue(5'd1, 5'd7, 1, 0);
    exe_wen = 1; exe_is_load = 1; exe_waddr = 5'd7;
    #1 check("no_stall_unused", 32'(stl[1]), 32'd0);
    step();
    idle(); wb_wen = 1; wb_waddr = 5'd0; wb_wdata = 32'hFF;
    step();
    idle(); issue(5'd0, 5'd0, 1, 1);
    step();
    check("r0_zero", oda[1], 32'd0);

    // back-pressure hold, flush, then reset mid-hold
    idle(); issue(5'd2, 5'd3, 1, 1); in_pc = 32'hCAFE_0000;
    step();
    issue(5'd4, 5'd5, 1, 1); in_pc = 32'h0BAD_0000; out_ready = 0;
    repeat (3) step();
    check("hold_pc", opc[1], 32'hCAFE_0000);
    check("hold_valid", 32'(ov[1]), 32'd1);
    flush = 1;
    step();
    check("flush_valid", 32'(ov[1]), 32'd0);
    idle(); issue(5'd6, 5'd3, 1, 1);
    step();
    out_ready = 0;
    step();
    apply_reset();

    // random traffic on a small register window to provoke hazards
    for (int c = 0; c < 1500; c++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_raddr_a = AW'($urandom_range(0, 7));
      in_raddr_b = AW'($urandom_range(0, 7));
      in_use_a   = ($urandom_range(0, 4) != 0);
      in_use_b   = ($urandom_range(0, 4) != 0);
      in_pc      = $urandom; in_imm = $urandom;
      in_waddr   = AW'($urandom_range(0, 31));
      in_wen     = 1'($urandom); in_is_load = 1'($urandom);
      exe_wen    = 1'($urandom); exe_is_load = ($urandom_range(0, 2) == 0);
      exe_waddr  = AW'($urandom_range(0, 7)); exe_wdata = $urandom_range(0, 3);
      mem_wen    = 1'($urandom);
      mem_waddr  = AW'($urandom_range(0, 7)); mem_wdata = $urandom_range(0, 3);
      wb_wen     = 1'($urandom);
      wb_waddr   = AW'($urandom_range(0, 7)); wb_wdata = $urandom_range(0, 3);
      flush      = ($urandom_range(0, 9) == 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
